pipe_register: RTL and testbench

- Parameterised fixed-latency delay line (pipeline register chain) for a data word.
- Used in datapaths and testbench drivers to align a computed value with events that occur a fixed number of cycles later.
- Typical use: a 16-bit expected-value word delayed by 4 cycles.
- No handshake and no enable: the chain advances on every clock edge.

---
 rtl/pipe_register.sv | 48 ++++
 tb/tb_pipe_register.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipe_register.sv
// Fixed-latency delay line: the data word is shifted through NUM_STAGES flops
// on every rising clk edge. A synchronous active-low reset clears all stages.
module pipe_register #(
  parameter int NUM_STAGES = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] out
);

  generate
    if (NUM_STAGES < 0 || DATA_WIDTH < 1) begin : g_bad_params
      $error("pipe_register: illegal parameters NUM_STAGES=%0d DATA_WIDTH=%0d",
             NUM_STAGES, DATA_WIDTH);
      assign out = '0;
    end else if (NUM_STAGES == 0) begin : g_pass
      // Zero latency: plain wire, clock and reset intentionally unused.
      logic unused_sync;
      assign unused_sync = clk ^ reset;
      assign out         = in;
    end else begin : g_chain
      logic [DATA_WIDTH-1:0] stage_q [NUM_STAGES];
      logic [DATA_WIDTH-1:0] stage_d [NUM_STAGES];

      for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
          assign stage_d[k] = in;
        end else begin : g_body
          assign stage_d[k] = stage_q[k-1];
        end

        always_ff @(posedge clk) begin
          if (!reset) begin
            stage_q[k] <= '0;
          end else begin
            stage_q[k] <= stage_d[k];
          end
        end
      end

      // Output taken straight from the last flop.
      assign out = stage_q[NUM_STAGES-1];
    end
  endgenerate

endmodule

// File: tb/tb_pipe_register.sv
// Randomised scoreboard bench for pipe_register at (4,16), (1,8) and (0,16).
module tb_pipe_register;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in4, out4;
  logic [7:0]  in1, out1;
  logic [15:0] in0, out0;

  int checks = 0;
  int errors = 0;

  // Per-edge history of what each DUT sampled, indexed by modelled edge number.
  bit          hist_rst[$];
  logic [15:0] hist_in4[$];
  logic [15:0] hist_in1[$];
  logic [15:0] exp4_q[$];
  logic [15:0] exp1_q[$];
  int          edge_n = 0;

  pipe_register #(.NUM_STAGES(4), .DATA_WIDTH(16)) dut4 (
    .clk(clk), .reset(reset), .in(in4), .out(out4));
  pipe_register #(.NUM_STAGES(1), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .in(in1), .out(out1));
  pipe_register #(.NUM_STAGES(0), .DATA_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .in(in0), .out(out0));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Value seen on out after edge t: the word sampled n-1 edges earlier,
  // or zero if any edge in that window had reset low.
  function automatic logic [15:0] model(input int n, input bit use1, input int t);
    int first = t - n + 1;
    for (int j = (first < 0 ? 0 : first); j <= t; j++)
      if (!hist_rst[j]) return 16'h0000;
    if (first < 0) return 16'h0000;
    return use1 ? hist_in1[first] : hist_in4[first];
  endfunction

  // Drive one cycle's inputs at the falling edge and predict the next edge.
  task automatic step(input bit rst, input logic [15:0] v4, input logic [7:0] v1);
    @(negedge clk);
    reset = rst;
    in4   = v4;
    in1   = v1;
    in0   = 16'($urandom);
    hist_rst.push_back(rst);
    hist_in4.push_back(v4);
    hist_in1.push_back({8'h00, v1});
    exp4_q.push_back(model(4, 1'b0, edge_n));
    exp1_q.push_back(model(1, 1'b1, edge_n));
    edge_n++;
    #1;
    check("pass0_comb", out0, in0);
  endtask

  // Monitor: compare each registered output just after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp4_q.size() != 0) check("out4", out4, exp4_q.pop_front());
      if (exp1_q.size() != 0) check("out1", {8'h00, out1}, exp1_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0;
    in4   = '0;
    in1   = '0;
    in0   = '0;

    // Reset held for three edges, inputs ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 16'($urandom), 8'($urandom));

    // Counting stream after release.
    for (int i = 1; i <= 10; i++) step(1'b1, 16'(i), 8'($urandom));

    // Mid-stream reset discards in-flight 0xA00x words.
    for (int i = 0; i < 6; i++) step(1'b1, 16'hA000 + 16'(i), 8'($urandom));
    step(1'b0, 16'hA0FF, 8'($urandom));
    for (int i = 0; i < 8; i++) step(1'b1, 16'hB000 + 16'(i), 8'($urandom));

    // Reset glitch between edges must leave the chain untouched.
    step(1'b1, 16'h1357, 8'h11);
    #1 reset = 1'b0;
    #1 check("gl_zero_pass0", out0, in0);
    reset = 1'b1;
    #1;
    check("glitch_out4", out4, model(4, 1'b0, edge_n - 2));
    check("glitch_out1", {8'h00, out1}, model(1, 1'b1, edge_n - 2));

    // Full-width alternating pattern.
    for (int i = 0; i < 10; i++) step(1'b1, (i % 2 == 0) ? 16'hFFFF : 16'h0000, 8'($urandom));

    // Single-stage block: 0x5A then 0xC3, then a reset edge.
    step(1'b1, 16'($urandom), 8'h5A);
    step(1'b1, 16'($urandom), 8'hC3);
    step(1'b0, 16'($urandom), 8'hFF);

    // Random traffic with occasional reset edges.
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 9) != 0), 16'($urandom), 8'($urandom));

    // Drain.
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 8'($urandom));

    @(posedge clk);
    #3;
    check("sb4_drained", 16'(exp4_q.size()), 16'd0);
    check("sb1_drained", 16'(exp1_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
